// File: rtl/gestor_interrupciones_pkg.sv
// Shared definitions for the vectored interrupt sequencer.
//   estado_t   : sequencer state (INACTIVO / SERVICIO)
//   AW_DEF     : default address width, equal to the return-stack data width
//   VBASE_DEF  : default vector base; line i vectors to VBASE + i
package pkg_interrupciones;

    localparam int         AW_DEF    = 10;
    localparam logic [9:0] VBASE_DEF = 10'h3F0;

    typedef enum logic {
        INACTIVO = 1'b0,
        SERVICIO = 1'b1
    } estado_t;

endpackage

// File: rtl/gestor_interrupciones_if.sv
// CPU/stack bus between the interrupt sequencer and the return-address stack.
//   pc_sig       : CPU's own next PC, saved as the return address on entry
//   ret_pila     : stack read data, valid combinationally during a pop
//   pila_ocupada : CPU is using the stack itself this cycle
//   sel_pc       : CPU must load pc_out as next PC
//   pc_out       : override PC (vector or return address)
//   push/pop     : stack commands, ORed externally with the CPU's own
//   weSP         : stack-pointer write enable, asserted with push or pop
//   dato_pila    : data written to the stack on push
// Handshake: push/pop/weSP are single-cycle commands with no back-pressure;
// the stack executes them in the cycle they are high. pila_ocupada is the
// only "not ready" indication, and entry is held off while it is high.
// master = sequencer side, slave = CPU/stack side.
interface gestor_interrupciones_if #(
    parameter int AW = 10
);
    logic [AW-1:0] pc_sig;
    logic [AW-1:0] ret_pila;
    logic          pila_ocupada;
    logic          sel_pc;
    logic [AW-1:0] pc_out;
    logic          push;
    logic          pop;
    logic          weSP;
    logic [AW-1:0] dato_pila;

    modport master (
        input  pc_sig, ret_pila, pila_ocupada,
        output sel_pc, pc_out, push, pop, weSP, dato_pila
    );

    modport slave (
        output pc_sig, ret_pila, pila_ocupada,
        input  sel_pc, pc_out, push, pop, weSP, dato_pila
    );
endinterface

// File: rtl/gestor_interrupciones_detector_flancos.sv
// Rising-edge detector and pending-request register.
//   clk, reset : system clock, synchronous active-high reset
//   irq        : raw request lines
//   clr        : one-hot acknowledge, clears the matching pending bit
//   pendientes : pending request bits
module detector_flancos #(
    parameter int NIRQ = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq,
    input  logic [NIRQ-1:0] clr,
    output logic [NIRQ-1:0] pendientes
);

    logic [NIRQ-1:0] irq_prev;
    logic [NIRQ-1:0] subida;

    assign subida = irq & ~irq_prev;

    // A new rise in the same cycle as its acknowledge wins, so that
    // request is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_prev   <= '0;
            pendientes <= '0;
        end else begin
            irq_prev   <= irq;
            pendientes <= (pendientes & ~clr) | subida;
        end
    end

endmodule

// File: rtl/gestor_interrupciones.sv
// Vectored interrupt sequencer in front of the return-address stack.
// Latches request edges, picks the lowest pending index, and on entry
// redirects the PC to VBASE+index while pushing the return address.
// On reti it pops the stack and reloads the PC from it. Single level,
// no nesting.
//   clk, reset : system clock, synchronous active-high reset
//   irq        : peripheral request lines (rising edge raises a request)
//   ei, di     : enable / disable interrupts (di wins if both)
//   reti       : return-from-interrupt decoded this cycle
//   bus        : CPU/stack bus (master side)
//   ack        : one-hot acknowledge pulse in the entry cycle
//   pendientes : pending request bits
//   en_curso   : handler executing
//   estado     : current sequencer state, for observation
module gestor_interrupciones
    import pkg_interrupciones::*;
#(
    parameter int            NIRQ  = 4,
    parameter int            AW    = AW_DEF,
    parameter logic [AW-1:0] VBASE = AW'(VBASE_DEF)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NIRQ-1:0]         irq,
    input  logic                    ei,
    input  logic                    di,
    input  logic                    reti,
    gestor_interrupciones_if.master bus,
    output logic [NIRQ-1:0]         ack,
    output logic [NIRQ-1:0]         pendientes,
    output logic                    en_curso,
    output estado_t                 estado
);

    localparam int SW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

    estado_t       estado_q, estado_sig;
    logic          ie;
    logic [SW-1:0] sel;
    logic          toma, retorno;

    detector_flancos #(.NIRQ(NIRQ)) u_detector (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .clr        (ack),
        .pendientes (pendientes)
    );

    // Lowest index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        sel = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (pendientes[i]) sel = SW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)   ie <= 1'b0;
        else if (di) ie <= 1'b0;
        else if (ei) ie <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) estado_q <= INACTIVO;
        else       estado_q <= estado_sig;
    end

    // Entry is refused while the CPU owns the stack or issues reti, so the
    // two never fight over push/pop. A reti in service always pops, even
    // if pila_ocupada is (illegally) high at the same time.
    always_comb begin
        estado_sig = estado_q;
        toma       = 1'b0;
        retorno    = 1'b0;
        case (estado_q)
            INACTIVO: begin
                if (ie && (|pendientes) && !bus.pila_ocupada && !reti) begin
                    toma       = 1'b1;
                    estado_sig = SERVICIO;
                end
            end
            SERVICIO: begin
                if (reti) begin
                    retorno    = 1'b1;
                    estado_sig = INACTIVO;
                end
            end
            default: estado_sig = INACTIVO;
        endcase
    end

    always_comb begin
        bus.sel_pc    = toma | retorno;
        bus.push      = toma;
        bus.pop       = retorno;
        bus.weSP      = toma | retorno;
        bus.pc_out    = '0;
        bus.dato_pila = '0;
        ack           = '0;
        if (toma) begin
            bus.pc_out    = VBASE + AW'(sel);
            bus.dato_pila = bus.pc_sig;
            ack           = NIRQ'(1) << sel;
        end else if (retorno) begin
            bus.pc_out = bus.ret_pila;
        end
    end

    assign en_curso = (estado_q == SERVICIO);
    assign estado   = estado_q;

endmodule

// File: tb/tb_gestor_interrupciones.sv
module tb_gestor_interrupciones;
  import pkg_interrupciones::*;

  localparam logic [9:0] VB = 10'h3F0;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] irq = '0;
  logic ei = 1'b0, di = 1'b0, reti = 1'b0;
  logic [3:0] ack, pendientes;
  logic en_curso;
  estado_t estado_dbg;

  gestor_interrupciones_if #(.AW(10)) bus ();

  gestor_interrupciones #(.NIRQ(4), .AW(10), .VBASE(VB)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .ei         (ei),
    .di         (di),
    .reti       (reti),
    .bus        (bus),
    .ack        (ack),
    .pendientes (pendientes),
    .en_curso   (en_curso),
    .estado     (estado_dbg)
  );

  logic [32:0] obs;
  assign obs = {bus.sel_pc, bus.pc_out, bus.push, bus.pop, bus.weSP,
                bus.dato_pila, ack, pendientes, en_curso};

  int n_vec = 0;
  int n_err = 0;

  // reference model: pending set, enable flag, busy flag, last sampled irq
  logic [3:0] m_pend = '0, m_prev = '0;
  logic m_ie = 1'b0, m_busy = 1'b0;
  logic e_take, e_ret;
  logic [3:0] e_ack;
  logic [32:0] e_vec;
  logic [32:0] exp_q[$];

  task automatic modelo_salidas();
    int k;
    logic [9:0] pc, dato;
    k = 0;
    for (int i = 3; i >= 0; i--) if (m_pend[i]) k = i;
    e_take = !m_busy && m_ie && (m_pend != 0) && !bus.pila_ocupada && !reti;
    e_ret  = m_busy && reti;
    e_ack  = e_take ? (4'b0001 << k) : 4'b0000;
    pc     = e_take ? (VB + 10'(k)) : (e_ret ? bus.ret_pila : 10'h000);
    dato   = e_take ? bus.pc_sig : 10'h000;
    e_vec  = {e_take | e_ret, pc, e_take, e_ret, e_take | e_ret, dato,
              e_ack, m_pend, m_busy};
  endtask

  task automatic reloj();
    modelo_salidas();
    @(posedge clk);
    if (reset) begin
      m_pend = '0; m_prev = '0; m_ie = 1'b0; m_busy = 1'b0;
    end else begin
      m_pend = (m_pend & ~e_ack) | (irq & ~m_prev);
      m_prev = irq;
      if (di) m_ie = 1'b0;
      else if (ei) m_ie = 1'b1;
      if (e_take) m_busy = 1'b1;
      else if (e_ret) m_busy = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; irq = '0; ei = 1'b0; di = 1'b0; reti = 1'b0;
    bus.pila_ocupada = 1'b0; bus.pc_sig = '0; bus.ret_pila = '0;
    reloj();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++;
    if (obs !== 33'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want %h", obs, 33'h0);
    end
  endtask

  task automatic test_entrada();
    do_reset();
    ei = 1'b1; reloj(); ei = 1'b0;
    irq = 4'b0100; bus.pc_sig = 10'h045; reloj();
    #1;
    n_vec++;
    if (pendientes !== 4'b0100) begin
      n_err++; $display("FAIL entry_pending: got %b want 0100", pendientes);
    end
    n_vec++;
    if ({bus.sel_pc, bus.push, bus.weSP, bus.pop} !== 4'b1110) begin
      n_err++;
      $display("FAIL entry_strobes: got %b want 1110", {bus.sel_pc, bus.push, bus.weSP, bus.pop});
    end
    n_vec++;
    if (bus.pc_out !== 10'h3F2) begin
      n_err++; $display("FAIL entry_vector: got %h want 3f2", bus.pc_out);
    end
    n_vec++;
    if (bus.dato_pila !== 10'h045 || ack !== 4'b0100) begin
      n_err++;
      $display("FAIL entry_push_ack: got dato=%h ack=%b want dato=045 ack=0100", bus.dato_pila, ack);
    end
    reloj();
    #1;
    n_vec++;
    if (en_curso !== 1'b1 || pendientes !== 4'b0000 || bus.sel_pc !== 1'b0) begin
      n_err++;
      $display("FAIL entry_after: got en=%b pend=%b sel_pc=%b want en=1 pend=0000 sel_pc=0", en_curso, pendientes, bus.sel_pc);
    end
  endtask

  task automatic test_anidado();
    irq = 4'b1101; reloj();
    #1;
    n_vec++;
    if (pendientes !== 4'b1001 || bus.sel_pc !== 1'b0 || bus.push !== 1'b0) begin
      n_err++;
      $display("FAIL nested_latched: got pend=%b sel_pc=%b push=%b want 1001 0 0", pendientes, bus.sel_pc, bus.push);
    end
    reti = 1'b1; bus.ret_pila = 10'h045;
    #1;
    n_vec++;
    if ({bus.pop, bus.weSP, bus.sel_pc, bus.push} !== 4'b1110 || bus.pc_out !== 10'h045) begin
      n_err++;
      $display("FAIL reti_return: got strobes=%b pc=%h want 1110 045", {bus.pop, bus.weSP, bus.sel_pc, bus.push}, bus.pc_out);
    end
    reloj(); reti = 1'b0;
    #1;
    n_vec++;
    if (bus.pc_out !== 10'h3F0 || ack !== 4'b0001 || bus.push !== 1'b1) begin
      n_err++;
      $display("FAIL back_to_back: got pc=%h ack=%b push=%b want 3f0 0001 1", bus.pc_out, ack, bus.push);
    end
    reloj();
  endtask

  task automatic test_ie();
    do_reset();
    irq = 4'b0010; reloj();
    #1;
    n_vec++;
    if (pendientes !== 4'b0010 || bus.sel_pc !== 1'b0) begin
      n_err++;
      $display("FAIL ie_off: got pend=%b sel_pc=%b want 0010 0", pendientes, bus.sel_pc);
    end
    ei = 1'b1; di = 1'b1; reloj(); ei = 1'b0; di = 1'b0;
    #1;
    n_vec++;
    if (bus.sel_pc !== 1'b0) begin
      n_err++; $display("FAIL ei_di_same: got sel_pc=%b want 0", bus.sel_pc);
    end
    ei = 1'b1; reloj(); ei = 1'b0;
    #1;
    n_vec++;
    if (bus.sel_pc !== 1'b1 || bus.pc_out !== 10'h3F1 || ack !== 4'b0010) begin
      n_err++;
      $display("FAIL ei_entry: got sel_pc=%b pc=%h ack=%b want 1 3f1 0010", bus.sel_pc, bus.pc_out, ack);
    end
    reloj();
  endtask

  task automatic test_pila_ocupada();
    do_reset();
    ei = 1'b1; reloj(); ei = 1'b0;
    irq = 4'b0010; reloj();
    bus.pila_ocupada = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (bus.push !== 1'b0 || bus.sel_pc !== 1'b0) begin
        n_err++;
        $display("FAIL stack_busy_%0d: got push=%b sel_pc=%b want 0 0", c, bus.push, bus.sel_pc);
      end
      reloj();
    end
    bus.pila_ocupada = 1'b0;
    #1;
    n_vec++;
    if (bus.push !== 1'b1 || bus.pc_out !== 10'h3F1) begin
      n_err++;
      $display("FAIL stack_free_entry: got push=%b pc=%h want 1 3f1", bus.push, bus.pc_out);
    end
    reloj();
  endtask

  task automatic test_nivel();
    int n_ack;
    do_reset();
    ei = 1'b1; reloj(); ei = 1'b0;
    irq = 4'b0100;
    n_ack = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (ack != 4'b0000) n_ack++;
      reloj();
    end
    n_vec++;
    if (n_ack !== 1 || pendientes !== 4'b0000 || en_curso !== 1'b1) begin
      n_err++;
      $display("FAIL held_level: got acks=%0d pend=%b en=%b want 1 0000 1", n_ack, pendientes, en_curso);
    end
    reti = 1'b1; reloj();
    #1;
    n_vec++;
    if (bus.pop !== 1'b0 || bus.sel_pc !== 1'b0) begin
      n_err++;
      $display("FAIL reti_idle: got pop=%b sel_pc=%b want 0 0", bus.pop, bus.sel_pc);
    end
    reti = 1'b0; reloj();
  endtask

  task automatic test_reset_servicio();
    do_reset();
    ei = 1'b1; reloj(); ei = 1'b0;
    irq = 4'b0001; reloj(); reloj();
    irq = 4'b0111; reloj();
    #1;
    n_vec++;
    if (pendientes !== 4'b0110 || en_curso !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset: got pend=%b en=%b want 0110 1", pendientes, en_curso);
    end
    reset = 1'b1; reloj(); reset = 1'b0;
    #1;
    n_vec++;
    if (en_curso !== 1'b0 || pendientes !== 4'b0000 ||
        {bus.sel_pc, bus.push, bus.pop, bus.weSP} !== 4'b0000 || ack !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_in_service: got en=%b pend=%b strobes=%b ack=%b want 0 0000 0000 0000",
               en_curso, pendientes, {bus.sel_pc, bus.push, bus.pop, bus.weSP}, ack);
    end
    reloj();
    #1;
    n_vec++;
    if (pendientes !== 4'b0111 || bus.sel_pc !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_ie: got pend=%b sel_pc=%b want 0111 0", pendientes, bus.sel_pc);
    end
    reloj();
  endtask

  task automatic test_aleatorio();
    logic [32:0] want;
    for (int c = 0; c < 600; c++) begin
      irq = irq ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      ei = ($urandom_range(0, 5) == 0);
      di = ($urandom_range(0, 11) == 0);
      reti = ($urandom_range(0, 3) == 0);
      bus.pila_ocupada = ($urandom_range(0, 4) == 0);
      bus.pc_sig = 10'($urandom);
      bus.ret_pila = 10'($urandom);
      reset = ($urandom_range(0, 149) == 0);
      #1;
      modelo_salidas();
      exp_q.push_back(e_vec);
      want = exp_q.pop_front();
      n_vec++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL random_cycle_%0d: got %h want %h", c, obs, want);
      end
      reloj();
    end
    reset = 1'b0;
  endtask

  initial begin
    bus.pila_ocupada = 1'b0; bus.pc_sig = '0; bus.ret_pila = '0;
    @(negedge clk);
    test_reset();
    test_entrada();
    test_anidado();
    test_ie();
    test_pila_ocupada();
    test_nivel();
    test_reset_servicio();
    test_aleatorio();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
